// File: rtl/spindle_contactor_drv.sv
// Spindle contactor driver: energises the coil on a synced run request, confirms pull-in and
// release through the debounced aux contact, enforces a restart hold-off and latches coded faults.
module spindle_contactor_drv #(
  parameter int FB_TIMEOUT      = 2_500_000,
  parameter int DEBOUNCE        = 50_000,
  parameter int RESTART_HOLDOFF = 25_000_000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       req,
  input  logic       estop_n,
  input  logic       aux_fb,
  input  logic       fault_clr,
  output logic       coil,
  output logic       running,
  output logic       fault,
  output logic [1:0] fault_code
);

  localparam int TMAX_P = (FB_TIMEOUT > RESTART_HOLDOFF) ? FB_TIMEOUT : RESTART_HOLDOFF;
  localparam int TW     = $clog2(TMAX_P) + 1;
  localparam int DW     = $clog2(DEBOUNCE) + 1;

  localparam logic [TW-1:0] FB_LAST = TW'(FB_TIMEOUT - 1);
  localparam logic [TW-1:0] HO_LAST = TW'(RESTART_HOLDOFF - 1);
  localparam logic [DW-1:0] DB_LAST = DW'(DEBOUNCE - 1);

  localparam logic [1:0] FC_ESTOP   = 2'b00;
  localparam logic [1:0] FC_PULLIN  = 2'b01;
  localparam logic [1:0] FC_RELEASE = 2'b10;
  localparam logic [1:0] FC_DROPOUT = 2'b11;

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_ENGAGE    = 3'd1,
    S_RUN       = 3'd2,
    S_DISENGAGE = 3'd3,
    S_HOLDOFF   = 3'd4,
    S_FAULT     = 3'd5
  } state_e;

  // {req, estop_n, aux_fb, fault_clr}
  logic [3:0]    sync1_q, sync2_q;
  logic          clr_prev_q;
  logic [1:0]    init_q, init_d;
  logic          req_s, estop_s, aux_s, clr_s, clr_rise_s, sync_ok_s;

  state_e        state_q, state_d;
  logic [TW-1:0] timer_q, timer_d;
  logic          fb_db_q, fb_db_d;
  logic [DW-1:0] db_cnt_q, db_cnt_d;
  logic          coil_q, coil_d;
  logic          running_q, running_d;
  logic          fault_q, fault_d;
  logic [1:0]    fault_code_q, fault_code_d;

  assign req_s      = sync2_q[3];
  assign estop_s    = sync2_q[2];
  assign aux_s      = sync2_q[1];
  assign clr_s      = sync2_q[0];
  assign clr_rise_s = clr_s & ~clr_prev_q;
  // The synchronisers hold reset zeros for two edges; the FSM waits so a reset-state estop
  // sample is not mistaken for a real E-stop.
  assign sync_ok_s  = init_q[1];

  // Synchroniser chains and fault_clr edge history
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q    <= 4'b0000;
      sync2_q    <= 4'b0000;
      clr_prev_q <= 1'b0;
      init_q     <= 2'd0;
    end else begin
      sync1_q    <= {req, estop_n, aux_fb, fault_clr};
      sync2_q    <= sync1_q;
      clr_prev_q <= clr_s;
      init_q     <= init_d;
    end
  end

  // Start-up qualifier and aux feedback debounce
  always_comb begin
    init_d   = sync_ok_s ? init_q : init_q + 2'd1;
    fb_db_d  = fb_db_q;
    db_cnt_d = '0;
    if (aux_s != fb_db_q) begin
      if (db_cnt_q == DB_LAST) begin
        fb_db_d  = aux_s;
        db_cnt_d = '0;
      end else begin
        db_cnt_d = db_cnt_q + DW'(1);
      end
    end else begin
      db_cnt_d = '0;
    end
  end

  // State register, timer and registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      timer_q      <= '0;
      fb_db_q      <= 1'b0;
      db_cnt_q     <= '0;
      coil_q       <= 1'b0;
      running_q    <= 1'b0;
      fault_q      <= 1'b0;
      fault_code_q <= FC_ESTOP;
    end else begin
      state_q      <= state_d;
      timer_q      <= timer_d;
      fb_db_q      <= fb_db_d;
      db_cnt_q     <= db_cnt_d;
      coil_q       <= coil_d;
      running_q    <= running_d;
      fault_q      <= fault_d;
      fault_code_q <= fault_code_d;
    end
  end

  // Next-state logic: estop first, then feedback and timeout checks, then the request
  always_comb begin
    state_d      = state_q;
    fault_code_d = fault_code_q;
    if (!sync_ok_s) begin
      state_d = state_q;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (!estop_s) begin
            state_d = S_FAULT; fault_code_d = FC_ESTOP;
          end else if (fb_db_q) begin
            state_d = S_FAULT; fault_code_d = FC_RELEASE;
          end else if (req_s) begin
            state_d = S_ENGAGE;
          end else begin
            state_d = S_IDLE;
          end
        end
        S_ENGAGE: begin
          if (!estop_s) begin
            state_d = S_FAULT; fault_code_d = FC_ESTOP;
          end else if (fb_db_q) begin
            state_d = S_RUN;
          end else if (timer_q == FB_LAST) begin
            state_d = S_FAULT; fault_code_d = FC_PULLIN;
          end else if (!req_s) begin
            state_d = S_DISENGAGE;
          end else begin
            state_d = S_ENGAGE;
          end
        end
        S_RUN: begin
          if (!estop_s) begin
            state_d = S_FAULT; fault_code_d = FC_ESTOP;
          end else if (!fb_db_q) begin
            state_d = S_FAULT; fault_code_d = FC_DROPOUT;
          end else if (!req_s) begin
            state_d = S_DISENGAGE;
          end else begin
            state_d = S_RUN;
          end
        end
        S_DISENGAGE: begin
          if (!estop_s) begin
            state_d = S_FAULT; fault_code_d = FC_ESTOP;
          end else if (!fb_db_q) begin
            state_d = S_HOLDOFF;
          end else if (timer_q == FB_LAST) begin
            state_d = S_FAULT; fault_code_d = FC_RELEASE;
          end else begin
            state_d = S_DISENGAGE;
          end
        end
        S_HOLDOFF: begin
          if (!estop_s) begin
            state_d = S_FAULT; fault_code_d = FC_ESTOP;
          end else if (timer_q == HO_LAST) begin
            state_d = S_IDLE;
          end else begin
            state_d = S_HOLDOFF;
          end
        end
        S_FAULT: begin
          if (clr_rise_s && estop_s && !req_s && !fb_db_q) begin
            state_d = S_HOLDOFF;
          end else begin
            state_d = S_FAULT;
          end
        end
        default: begin
          state_d = S_IDLE;
        end
      endcase
    end

    if (state_d != state_q) begin
      timer_d = '0;
    end else if (timer_q == {TW{1'b1}}) begin
      timer_d = timer_q;
    end else begin
      timer_d = timer_q + TW'(1);
    end
  end

  // Output decode from the next state so outputs change on the same edge as the state
  always_comb begin
    coil_d    = 1'b0;
    running_d = 1'b0;
    fault_d   = 1'b0;
    case (state_d)
      S_ENGAGE: coil_d = 1'b1;
      S_RUN: begin
        coil_d    = 1'b1;
        running_d = 1'b1;
      end
      S_FAULT:  fault_d = 1'b1;
      default: begin
        coil_d    = 1'b0;
        running_d = 1'b0;
        fault_d   = 1'b0;
      end
    endcase
  end

  assign coil       = coil_q & estop_s;
  assign running    = running_q;
  assign fault      = fault_q;
  assign fault_code = fault_code_q;

endmodule

// File: tb/tb_spindle_contactor_drv.sv
// Scoreboard bench for spindle_contactor_drv: per-cycle expected outputs are queued as stimulus
// is applied and compared one per clock as the DUT advances.
module tb_spindle_contactor_drv;

  logic       clk = 1'b0;
  logic       rst_n, req, estop_n, aux_fb, fault_clr;
  logic       coil, running, fault;
  logic [1:0] fault_code;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    string      tag;
    logic       c;
    logic       r;
    logic       f;
    logic [1:0] code;
  } exp_t;

  exp_t exp_q[$];

  spindle_contactor_drv #(
    .FB_TIMEOUT(20),
    .DEBOUNCE(4),
    .RESTART_HOLDOFF(10)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .req(req),
    .estop_n(estop_n),
    .aux_fb(aux_fb),
    .fault_clr(fault_clr),
    .coil(coil),
    .running(running),
    .fault(fault),
    .fault_code(fault_code)
  );

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic push_n(input string tag, input int n, input logic c, input logic r,
                        input logic f, input logic [1:0] code);
    exp_t e;
    e.tag = tag; e.c = c; e.r = r; e.f = f; e.code = code;
    for (int i = 0; i < n; i++) exp_q.push_back(e);
  endtask

  task automatic check_out();
    exp_t e;
    if (exp_q.size() == 0) begin
      check_val("scoreboard_empty", 32'd0, 32'd1);
    end else begin
      e = exp_q.pop_front();
      check_val(e.tag, {29'd0, coil, running, fault}, {29'd0, e.c, e.r, e.f});
      if (e.f) check_val({e.tag, "_code"}, {30'd0, fault_code}, {30'd0, e.code});
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Advance one clock per queued expectation and compare until the queue drains
  task automatic run_queue();
    int guard;
    guard = 0;
    while (exp_q.size() != 0 && guard < 1000) begin
      tick();
      check_out();
      guard++;
    end
    if (exp_q.size() != 0) begin
      check_val("queue_drain_timeout", 32'd0, 32'd1);
      exp_q.delete();
    end
  endtask

  initial begin
    rst_n = 1'b0; req = 1'b0; estop_n = 1'b1; aux_fb = 1'b0; fault_clr = 1'b0;
    #2;
    push_n("reset", 1, 1'b0, 1'b0, 1'b0, 2'b00);
    check_out();
    check_val("reset_code", {30'd0, fault_code}, 32'd0);
    #1 rst_n = 1'b1;
    push_n("idle_after_reset", 5, 1'b0, 1'b0, 1'b0, 2'b00);
    run_queue();

    // 1: normal engage, run, release, hold-off
    req = 1'b1;
    push_n("t1_sync", 2, 1'b0, 1'b0, 1'b0, 2'b00);
    push_n("t1_coil_edge3", 1, 1'b1, 1'b0, 1'b0, 2'b00);
    push_n("t1_engage", 8, 1'b1, 1'b0, 1'b0, 2'b00);
    run_queue();
    aux_fb = 1'b1;
    push_n("t1_debounce", 6, 1'b1, 1'b0, 1'b0, 2'b00);
    push_n("t1_running", 1, 1'b1, 1'b1, 1'b0, 2'b00);
    run_queue();
    req = 1'b0;
    push_n("t1_req_sync", 2, 1'b1, 1'b1, 1'b0, 2'b00);
    push_n("t1_disengage", 1, 1'b0, 1'b0, 1'b0, 2'b00);
    run_queue();
    aux_fb = 1'b0;
    push_n("t1_release_holdoff", 19, 1'b0, 1'b0, 1'b0, 2'b00);
    run_queue();

    // 2: pull-in timeout exactly 20 cycles after ENGAGE entry
    req = 1'b1;
    push_n("t2_sync", 2, 1'b0, 1'b0, 1'b0, 2'b00);
    push_n("t2_engage", 20, 1'b1, 1'b0, 1'b0, 2'b00);
    push_n("t2_pullin_fault", 1, 1'b0, 1'b0, 1'b1, 2'b01);
    run_queue();
    req = 1'b0;
    push_n("t2_fault_hold", 3, 1'b0, 1'b0, 1'b1, 2'b01);
    run_queue();
    fault_clr = 1'b1;
    push_n("t2_clr_sync", 2, 1'b0, 1'b0, 1'b1, 2'b01);
    push_n("t2_cleared", 1, 1'b0, 1'b0, 1'b0, 2'b00);
    run_queue();
    fault_clr = 1'b0;
    push_n("t2_holdoff", 12, 1'b0, 1'b0, 1'b0, 2'b00);
    run_queue();

    // 3: welded contact seen in IDLE
    aux_fb = 1'b1;
    push_n("t3_no_coil", 6, 1'b0, 1'b0, 1'b0, 2'b00);
    push_n("t3_welded_fault", 1, 1'b0, 1'b0, 1'b1, 2'b10);
    run_queue();
    aux_fb = 1'b0;
    push_n("t3_fault_hold", 8, 1'b0, 1'b0, 1'b1, 2'b10);
    run_queue();
    fault_clr = 1'b1;
    push_n("t3_clr_sync", 2, 1'b0, 1'b0, 1'b1, 2'b10);
    push_n("t3_cleared", 1, 1'b0, 1'b0, 1'b0, 2'b00);
    run_queue();
    fault_clr = 1'b0;
    push_n("t3_holdoff", 12, 1'b0, 1'b0, 1'b0, 2'b00);
    run_queue();

    // 4: E-stop in RUN, then recovery
    req = 1'b1; aux_fb = 1'b1;
    push_n("t4_sync", 2, 1'b0, 1'b0, 1'b0, 2'b00);
    push_n("t4_engage", 4, 1'b1, 1'b0, 1'b0, 2'b00);
    push_n("t4_running", 1, 1'b1, 1'b1, 1'b0, 2'b00);
    run_queue();
    estop_n = 1'b0;
    push_n("t4_estop_sync1", 1, 1'b1, 1'b1, 1'b0, 2'b00);
    push_n("t4_coil_gated", 1, 1'b0, 1'b1, 1'b0, 2'b00);
    push_n("t4_estop_fault", 1, 1'b0, 1'b0, 1'b1, 2'b00);
    run_queue();
    estop_n = 1'b1; req = 1'b0; aux_fb = 1'b0;
    push_n("t4_fault_hold", 8, 1'b0, 1'b0, 1'b1, 2'b00);
    run_queue();
    fault_clr = 1'b1;
    push_n("t4_clr_sync", 2, 1'b0, 1'b0, 1'b1, 2'b00);
    push_n("t4_cleared", 1, 1'b0, 1'b0, 1'b0, 2'b00);
    run_queue();
    fault_clr = 1'b0;
    push_n("t4_holdoff", 12, 1'b0, 1'b0, 1'b0, 2'b00);
    run_queue();

    // 5: run dropout, discarded clear with req high, hold-off ignores req
    req = 1'b1; aux_fb = 1'b1;
    push_n("t5_sync", 2, 1'b0, 1'b0, 1'b0, 2'b00);
    push_n("t5_engage", 4, 1'b1, 1'b0, 1'b0, 2'b00);
    push_n("t5_running", 1, 1'b1, 1'b1, 1'b0, 2'b00);
    run_queue();
    aux_fb = 1'b0;
    push_n("t5_still_running", 6, 1'b1, 1'b1, 1'b0, 2'b00);
    push_n("t5_dropout_fault", 1, 1'b0, 1'b0, 1'b1, 2'b11);
    run_queue();
    fault_clr = 1'b1;
    push_n("t5_clr_ignored", 4, 1'b0, 1'b0, 1'b1, 2'b11);
    run_queue();
    fault_clr = 1'b0;
    push_n("t5_clr_low", 2, 1'b0, 1'b0, 1'b1, 2'b11);
    run_queue();
    req = 1'b0;
    push_n("t5_req_low", 3, 1'b0, 1'b0, 1'b1, 2'b11);
    run_queue();
    fault_clr = 1'b1;
    push_n("t5_clr_sync", 2, 1'b0, 1'b0, 1'b1, 2'b11);
    push_n("t5_cleared", 1, 1'b0, 1'b0, 1'b0, 2'b00);
    run_queue();
    fault_clr = 1'b0; req = 1'b1;
    push_n("t5_holdoff_ignores_req", 10, 1'b0, 1'b0, 1'b0, 2'b00);
    push_n("t5_engage_after_idle", 1, 1'b1, 1'b0, 1'b0, 2'b00);
    run_queue();

    // 6: reset mid-ENGAGE, restart without fault_clr
    push_n("t6_engage", 2, 1'b1, 1'b0, 1'b0, 2'b00);
    run_queue();
    rst_n = 1'b0;
    #1;
    push_n("t6_async_reset", 1, 1'b0, 1'b0, 1'b0, 2'b00);
    check_out();
    check_val("t6_reset_code", {30'd0, fault_code}, 32'd0);
    #3 rst_n = 1'b1;
    push_n("t6_restart_sync", 2, 1'b0, 1'b0, 1'b0, 2'b00);
    push_n("t6_restart_coil", 1, 1'b1, 1'b0, 1'b0, 2'b00);
    run_queue();
    aux_fb = 1'b1;
    push_n("t6_debounce", 6, 1'b1, 1'b0, 1'b0, 2'b00);
    push_n("t6_running", 1, 1'b1, 1'b1, 1'b0, 2'b00);
    run_queue();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
